irq_sched: RTL and testbench
============================

Name: irq_sched

Overview:
- Interrupt scheduler between the timer/counter peripherals and the CPU core.
- Captures interrupt requests from up to 8 sources and masks them with a software enable register.
- Selects one winner by fixed or round-robin priority, drives the single CPU interrupt_request/interrupt_executed handshake, and returns a one-cycle acknowledge to the serviced source.
- Configured through the same 8-bit register bus (write/read/addr/wdata/rdata) as the timers.

Parameters:
- NSRC, 4, number of interrupt sources (1..8).
- VW, 3, vector width; must satisfy 2**VW >= NSRC.
- BASE, 8'h70, bus address of the first register. IEN=BASE, IPEND=BASE+1, ICFG=BASE+2, IVEC=BASE+3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- write  in  1  bus write strobe.
- read  in  1  bus read strobe.
- addr  in  8  bus address.
- wdata  in  8  bus write data.
- rdata  out  8  bus read data, registered.
- irq_req  in  NSRC  per-source request, level from the peripheral.
- irq_ack  out  NSRC  per-source service acknowledge, one-cycle pulse.
- interrupt_request  out  1  request to the CPU.
- interrupt_executed  in  1  CPU service indication, sampled only in REQ.
- irq_vector  out  VW  index of the source being requested.

Behaviour:
- Reset (rst==0 at a rising edge): all of the following go to 0 and the FSM enters IDLE.
  - Outputs: rdata, irq_ack, interrupt_request, irq_vector.
  - Internal: IEN, IPEND, ICFG, the irq_req delay register, and the round-robin pointer ptr.
  - Reset mid-handshake drops interrupt_request the next cycle and issues no ack.
- Registers (bits at or above NSRC read 0 and ignore writes):
  - IEN: read/write.
  - IPEND: read; write-1-to-clear.
  - ICFG: bit0 = rr mode (0 fixed, 1 round-robin), bit1 = global enable, others read 0.
  - IVEC: read-only, {interrupt_request, 7-VW zeros, irq_vector}.
- Bus rules:
  - Read: rdata is updated at the clock edge where read=1; 1-cycle latency; holds otherwise.
  - write and read both 1: the write executes and rdata holds.
  - Unmapped read returns 8'h00. Unmapped write is ignored.
- Capture:
  - pending[i] is set when irq_req[i]=1 and the previous sample was 0 (rising edge).
  - A set wins over a W1C clear or a service clear in the same cycle.
- Arbitration: eligible = IPEND & IEN, gated by global enable.
  - Fixed mode: lowest eligible index wins.
  - Round-robin mode: first eligible index at or above ptr, wrapping modulo NSRC.
- FSM states: IDLE, REQ, ACK.
  - IDLE: if eligible != 0, latch winner into irq_vector, set interrupt_request=1, go to REQ.
  - REQ: interrupt_request and irq_vector are held stable.
    - On interrupt_executed=1: interrupt_request=0, pending[irq_vector] cleared, irq_ack[irq_vector]=1, ptr=(irq_vector+1) mod NSRC, go to ACK.
    - Otherwise, if the latched source is no longer eligible (disabled, W1C-cleared, or global enable off): interrupt_request=0, go to IDLE, no ack.
    - interrupt_executed has priority over withdrawal in the same cycle.
  - ACK: irq_ack returns to 0, go to IDLE. This gives a minimum of one cycle with interrupt_request low between services.
- Latency: irq_req rises before edge k (low before k-1), with the source enabled and IDLE. pending is visible after edge k; interrupt_request=1 after edge k+1.
- ptr advances only on service, never on withdrawal.

Test Plan:
- Reset/registers: rst=0 for 2 cycles -> all outputs 0. Write IEN=8'h0F at 8'h70, read 8'h70 -> rdata=8'h0F one cycle later. Write 8'hFF to 8'h72 -> reads 8'h03. Read 8'h7F -> 8'h00.
- Single service: ICFG=8'h02, IEN=8'h0F, pulse irq_req[2].
  - interrupt_request=1 two edges later, irq_vector=2, IVEC reads 8'h82.
  - Assert interrupt_executed -> irq_ack=4'b0100 for one cycle, IPEND reads 0.
- Fixed priority: irq_req[3] and irq_req[1] rise together -> vector 1 served first, then vector 3 after the ACK gap.
- Round-robin: ICFG=8'h03, keep sources 0,1,2 re-pulsed after each ack -> service order 0,1,2,0.
- Withdrawal: source 0 requested, write IPEND=8'h01 while in REQ -> interrupt_request drops next cycle, no irq_ack, ptr unchanged. Repeat with interrupt_executed in the same cycle -> ack issued.
- Set/clear collision: W1C write to IPEND bit 1 in the same cycle as a new rising edge on irq_req[1] -> pending[1] stays 1.

Source files
------------

// File: rtl/irq_sched_if.sv
// irq_sched bus + CPU handshake bundle.
// master drives strobes/requests; slave is the scheduler.
interface irq_sched_if #(
  parameter int NSRC = 4,
  parameter int VW   = 3
);
  logic            write;
  logic            read;
  logic [7:0]      addr;
  logic [7:0]      wdata;
  logic [7:0]      rdata;
  logic [NSRC-1:0] irq_req;
  logic [NSRC-1:0] irq_ack;
  logic            interrupt_request;
  logic            interrupt_executed;
  logic [VW-1:0]   irq_vector;

  modport master (
    output write, read, addr, wdata,
    output irq_req, interrupt_executed,
    input  rdata, irq_ack,
    input  interrupt_request, irq_vector
  );

  modport slave (
    input  write, read, addr, wdata,
    input  irq_req, interrupt_executed,
    output rdata, irq_ack,
    output interrupt_request, irq_vector
  );
endinterface

// File: rtl/irq_sched.sv
// irq_sched: edge-captured, masked, fixed/round-robin interrupt scheduler.
// Ports: clk, rst (sync, active low), bus (irq_sched_if.slave).
module irq_sched #(
  parameter int         NSRC = 4,
  parameter int         VW   = 3,
  parameter logic [7:0] BASE = 8'h70
) (
  input logic        clk,
  input logic        rst,
  irq_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  localparam logic [7:0] A_IEN = BASE;
  localparam logic [7:0] A_PND = BASE + 8'd1;
  localparam logic [7:0] A_CFG = BASE + 8'd2;
  localparam logic [7:0] A_VEC = BASE + 8'd3;

  state_t          r_state;
  logic [NSRC-1:0] r_irq_d;
  logic [NSRC-1:0] r_ien;
  logic [NSRC-1:0] r_pend;
  logic [1:0]      r_cfg;
  logic [VW-1:0]   r_ptr;
  logic [VW-1:0]   r_vec;
  logic            r_req;
  logic [NSRC-1:0] r_ack;
  logic [7:0]      r_rdata;

  logic            w_a_ien;
  logic            w_a_pnd;
  logic            w_a_cfg;
  logic            w_a_vec;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_w1c;
  logic [NSRC-1:0] w_vec_oh;
  logic [NSRC-1:0] w_svc;
  logic [NSRC-1:0] w_pend_nx;
  logic [NSRC-1:0] w_ien_nx;
  logic [1:0]      w_cfg_nx;
  logic [NSRC-1:0] w_elig;
  logic            w_keep;
  logic [VW-1:0]   w_ptr_nx;
  logic [VW-1:0]   w_win;
  int              w_j;
  logic [7:0]      w_rd;
  logic            w_unused;

  assign w_a_ien = (bus.addr == A_IEN);
  assign w_a_pnd = (bus.addr == A_PND);
  assign w_a_cfg = (bus.addr == A_CFG);
  assign w_a_vec = (bus.addr == A_VEC);
  assign w_unused = ^bus.wdata;

  assign w_rise   = bus.irq_req & ~r_irq_d;
  assign w_w1c    = (bus.write && w_a_pnd) ? bus.wdata[NSRC-1:0] : '0;
  assign w_vec_oh = NSRC'(1) << r_vec;
  assign w_svc    = (r_state == REQ && bus.interrupt_executed) ? w_vec_oh : '0;

  // A new rising edge outranks any clear in the same cycle.
  assign w_pend_nx = (r_pend & ~w_w1c & ~w_svc) | w_rise;
  assign w_ien_nx  = (bus.write && w_a_ien) ? bus.wdata[NSRC-1:0] : r_ien;
  assign w_cfg_nx  = (bus.write && w_a_cfg) ? bus.wdata[1:0] : r_cfg;

  assign w_elig = r_pend & r_ien & {NSRC{r_cfg[1]}};

  // Withdrawal looks at next-cycle state so a W1C/disable
  // drops the request at the same edge it takes effect.
  assign w_keep = (|(w_pend_nx & w_ien_nx & w_vec_oh)) & w_cfg_nx[1];

  assign w_ptr_nx = (r_vec == VW'(NSRC - 1)) ? '0 : r_vec + 1'b1;

  // Scan downward so the last hit is the first index from the start point.
  always_comb begin
    w_win = '0;
    w_j   = 0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      w_j = r_cfg[0] ? int'(r_ptr) + k : k;
      if (w_j >= NSRC) w_j = w_j - NSRC;
      if (w_elig[w_j]) w_win = VW'(w_j);
    end
  end

  always_comb begin
    w_rd = '0;
    unique case (1'b1)
      w_a_ien: w_rd = 8'(r_ien);
      w_a_pnd: w_rd = 8'(r_pend);
      w_a_cfg: w_rd = 8'(r_cfg);
      w_a_vec: begin
        w_rd    = 8'(r_vec);
        w_rd[7] = r_req;
      end
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_irq_d <= '0;
      r_ien   <= '0;
      r_pend  <= '0;
      r_cfg   <= '0;
      r_ptr   <= '0;
      r_vec   <= '0;
      r_req   <= 1'b0;
      r_ack   <= '0;
      r_rdata <= '0;
    end else begin
      r_irq_d <= bus.irq_req;
      r_pend  <= w_pend_nx;
      r_ien   <= w_ien_nx;
      r_cfg   <= w_cfg_nx;
      r_ack   <= '0;
      if (bus.read && !bus.write) r_rdata <= w_rd;
      unique case (r_state)
        IDLE: begin
          if (|w_elig) begin
            r_vec   <= w_win;
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (bus.interrupt_executed) begin
            r_req   <= 1'b0;
            r_ack   <= w_vec_oh;
            r_ptr   <= w_ptr_nx;
            r_state <= ACK;
          end else if (!w_keep) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        ACK: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rdata             = r_rdata;
  assign bus.irq_ack           = r_ack;
  assign bus.interrupt_request = r_req;
  assign bus.irq_vector        = r_vec;

endmodule

// File: tb/tb_irq_sched.sv
// Testbench for irq_sched: scenario tasks with a vector scoreboard.
// Expected service order is queued at stimulus time, popped on service.
module tb_irq_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  irq_sched_if #(.NSRC(4), .VW(3)) bus ();

  irq_sched #(.NSRC(4), .VW(3), .BASE(8'h70)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.write = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    bus.read = 1'b1;
    bus.addr = a;
    tick();
    bus.read = 1'b0;
    d = bus.rdata;
  endtask

  task automatic pulse(input logic [3:0] m);
    bus.irq_req = bus.irq_req | m;
    tick();
    bus.irq_req = bus.irq_req & ~m;
  endtask

  task automatic wait_req(output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    while (!bus.interrupt_request && n < 20) begin
      tick();
      n++;
    end
    if (!bus.interrupt_request) to = 1'b1;
  endtask

  // Drives one service; returns vector, ack pulse, and state one cycle on.
  task automatic serve(output int v, output bit to,
                       output logic [3:0] ack, output logic [3:0] ack2,
                       output logic rq2);
    ack  = '0;
    ack2 = '0;
    rq2  = 1'b0;
    wait_req(to);
    v = int'(bus.irq_vector);
    if (to) return;
    bus.interrupt_executed = 1'b1;
    tick();
    ack = bus.irq_ack;
    bus.interrupt_executed = 1'b0;
    tick();
    ack2 = bus.irq_ack;
    rq2  = bus.interrupt_request;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.write = 0; bus.read = 0; bus.addr = 0; bus.wdata = 0;
    bus.irq_req = 0; bus.interrupt_executed = 0;
    tick();
    tick();
    total++;
    if (bus.rdata !== 8'h00) begin
      bad++; $display("FAIL rst_rdata got=%h exp=00", bus.rdata);
    end
    total++;
    if ({bus.irq_ack, bus.interrupt_request, bus.irq_vector} !== 8'h00) begin
      bad++;
      $display("FAIL rst_outs got ack=%b req=%b vec=%0d exp all 0",
               bus.irq_ack, bus.interrupt_request, bus.irq_vector);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_regs();
    logic [7:0] d;
    wr(8'h70, 8'h0F); rd(8'h70, d);
    total++;
    if (d !== 8'h0F) begin bad++; $display("FAIL ien_rd got=%h exp=0f", d); end
    wr(8'h70, 8'hFF); rd(8'h70, d);
    total++;
    if (d !== 8'h0F) begin bad++; $display("FAIL ien_hi got=%h exp=0f", d); end
    wr(8'h72, 8'hFF); rd(8'h72, d);
    total++;
    if (d !== 8'h03) begin bad++; $display("FAIL cfg_rd got=%h exp=03", d); end
    rd(8'h7F, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL unmapped got=%h exp=00", d); end
    rd(8'h70, d);
    bus.write = 1'b1; bus.read = 1'b1; bus.addr = 8'h72; bus.wdata = 8'h01;
    tick();
    bus.write = 1'b0; bus.read = 1'b0;
    total++;
    if (bus.rdata !== 8'h0F) begin
      bad++; $display("FAIL wr_rd_hold got=%h exp=0f", bus.rdata);
    end
    rd(8'h72, d);
    total++;
    if (d !== 8'h01) begin bad++; $display("FAIL wr_rd_wins got=%h exp=01", d); end
  endtask

  task automatic test_single();
    logic [7:0] d;
    int v; bit to; logic [3:0] a1, a2; logic r2; int e;
    wr(8'h72, 8'h02);
    wr(8'h70, 8'h0F);
    pulse(4'b0100);
    exp_q.push_back(2);
    total++;
    if (bus.interrupt_request !== 1'b0) begin
      bad++; $display("FAIL lat_early got=%b exp=0", bus.interrupt_request);
    end
    tick();
    total++;
    if ({bus.interrupt_request, bus.irq_vector} !== {1'b1, 3'd2}) begin
      bad++;
      $display("FAIL lat_req got req=%b vec=%0d exp req=1 vec=2",
               bus.interrupt_request, bus.irq_vector);
    end
    rd(8'h73, d);
    total++;
    if (d !== 8'h82) begin bad++; $display("FAIL ivec got=%h exp=82", d); end
    serve(v, to, a1, a2, r2);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    total++;
    if (to || v != e || a1 !== 4'b0100 || a2 !== 4'b0000) begin
      bad++;
      $display("FAIL single_svc got vec=%0d ack=%b/%b to=%0d exp vec=%0d ack=0100/0000",
               v, a1, a2, to, e);
    end
    rd(8'h71, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL pend_clr got=%h exp=00", d); end
  endtask

  task automatic test_fixed();
    int v; bit to; logic [3:0] a1, a2; logic r2; int e;
    logic [3:0] exp_ack [2];
    exp_ack[0] = 4'b0010;
    exp_ack[1] = 4'b1000;
    pulse(4'b1010);
    exp_q.push_back(1);
    exp_q.push_back(3);
    for (int k = 0; k < 2; k++) begin
      serve(v, to, a1, a2, r2);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      total++;
      if (to || v != e || a1 !== exp_ack[k] || r2 !== 1'b0) begin
        bad++;
        $display("FAIL fixed_%0d got vec=%0d ack=%b gapreq=%b to=%0d exp vec=%0d ack=%b gapreq=0",
                 k, v, a1, r2, to, e, exp_ack[k]);
      end
    end
  endtask

  task automatic test_rr();
    logic [7:0] d;
    int v; bit to; logic [3:0] a1, a2; logic r2; int e;
    rst = 1'b0; tick(); rst = 1'b1;
    wr(8'h72, 8'h03);
    wr(8'h70, 8'h0F);
    pulse(4'b0111);
    exp_q.push_back(0); exp_q.push_back(1);
    exp_q.push_back(2); exp_q.push_back(0);
    for (int k = 0; k < 4; k++) begin
      serve(v, to, a1, a2, r2);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      total++;
      if (to || v != e) begin
        bad++; $display("FAIL rr_%0d got vec=%0d to=%0d exp=%0d", k, v, to, e);
      end
      if (k < 3 && !to) pulse(4'(1 << v));
    end
    wr(8'h71, 8'h0F);
    tick(); tick(); tick();
    rd(8'h71, d);
    total++;
    if (d !== 8'h00 || bus.interrupt_request !== 1'b0) begin
      bad++;
      $display("FAIL rr_drain got pend=%h req=%b exp 00/0", d, bus.interrupt_request);
    end
  endtask

  task automatic test_withdraw();
    logic [7:0] d;
    int v; bit to; logic [3:0] a1, a2; logic r2; int e;
    pulse(4'b0100);
    wait_req(to);
    total++;
    if (to || bus.irq_vector !== 3'd2) begin
      bad++; $display("FAIL wd_req got vec=%0d to=%0d exp=2", bus.irq_vector, to);
    end
    wr(8'h71, 8'h04);
    total++;
    if (bus.interrupt_request !== 1'b0 || bus.irq_ack !== 4'b0000) begin
      bad++;
      $display("FAIL wd_drop got req=%b ack=%b exp 0/0000",
               bus.interrupt_request, bus.irq_ack);
    end
    tick();
    total++;
    if (bus.interrupt_request !== 1'b0 || bus.irq_ack !== 4'b0000) begin
      bad++;
      $display("FAIL wd_noack got req=%b ack=%b exp 0/0000",
               bus.interrupt_request, bus.irq_ack);
    end
    // ptr was 1 before the withdrawal; a bump to 3 would pick 3 here.
    pulse(4'b1010);
    exp_q.push_back(1);
    exp_q.push_back(3);
    for (int k = 0; k < 2; k++) begin
      serve(v, to, a1, a2, r2);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      total++;
      if (to || v != e) begin
        bad++; $display("FAIL wd_ptr_%0d got vec=%0d to=%0d exp=%0d", k, v, to, e);
      end
    end
    pulse(4'b0100);
    wait_req(to);
    bus.write = 1'b1; bus.addr = 8'h71; bus.wdata = 8'h04;
    bus.interrupt_executed = 1'b1;
    tick();
    bus.write = 1'b0;
    bus.interrupt_executed = 1'b0;
    total++;
    if (to || bus.irq_ack !== 4'b0100 || bus.interrupt_request !== 1'b0) begin
      bad++;
      $display("FAIL wd_exec_wins got ack=%b req=%b to=%0d exp 0100/0",
               bus.irq_ack, bus.interrupt_request, to);
    end
    tick();
    rd(8'h71, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL wd_pend got=%h exp=00", d); end
  endtask

  task automatic test_collision();
    logic [7:0] d;
    wr(8'h70, 8'h00);
    pulse(4'b0010);
    tick();
    bus.irq_req = 4'b0010;
    bus.write = 1'b1; bus.addr = 8'h71; bus.wdata = 8'h02;
    tick();
    bus.write = 1'b0;
    bus.irq_req = 4'b0000;
    rd(8'h71, d);
    total++;
    if (d !== 8'h02) begin bad++; $display("FAIL coll_set got=%h exp=02", d); end
    wr(8'h71, 8'h02);
    rd(8'h71, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL coll_w1c got=%h exp=00", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    bit to;
    wr(8'h70, 8'h0F);
    pulse(4'b0001);
    wait_req(to);
    rst = 1'b0;
    tick();
    total++;
    if (to || bus.interrupt_request !== 1'b0 || bus.irq_ack !== 4'b0000) begin
      bad++;
      $display("FAIL rst_mid got req=%b ack=%b to=%0d exp 0/0000",
               bus.interrupt_request, bus.irq_ack, to);
    end
    rst = 1'b1;
    tick();
    rd(8'h70, d);
    total++;
    if (d !== 8'h00 || bus.irq_ack !== 4'b0000) begin
      bad++; $display("FAIL rst_mid_ien got ien=%h ack=%b exp 00/0000", d, bus.irq_ack);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_regs();
    test_single();
    test_fixed();
    test_rr();
    test_withdraw();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
